// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM core pipeline control blocks.
//   - fsm_state_t   : memory-wait FSM state (RUN, MEM_WAIT, ERROR)
//   - FWD_*         : EXE operand forward-select encodings
//   - REG_AW_DEFAULT: default register address width
//   - fwd_pick()    : forward-select priority (MEM beats WB)
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int REG_AW_DEFAULT = 4;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } fsm_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // The MEM result is younger than the WB result, so on a double match the
  // MEM value is the architecturally current one.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Combinational EXE operand forward-select generation.
// Ports:
//   exe_src1/exe_src2   in  : EXE operand register addresses
//   mem_dest, mem_wb_en in  : MEM stage destination and its valid
//   wb_dest,  wb_wb_en  in  : WB stage destination and its valid
//   sel_src1/sel_src2   out : 00 register file, 01 MEM ALU result, 10 WB result
// ---------------------------------------------------------------------------
module forwarding_unit
  import arm_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] exe_src1,
  input  logic [REG_AW-1:0] exe_src2,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2
);

  assign sel_src1 = fwd_pick(mem_wb_en && (mem_dest == exe_src1),
                             wb_wb_en  && (wb_dest  == exe_src1));
  assign sel_src2 = fwd_pick(mem_wb_en && (mem_dest == exe_src2),
                             wb_wb_en  && (wb_dest  == exe_src2));

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Hazard / stall / flush / freeze control for the 5-stage ARM pipeline.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   : EXE RAW stalls only for load-use, MEM RAW ignored,
//               sel_src1/sel_src2 driven by forwarding_unit.
//   undefined : any EXE or MEM RAW match stalls, sel_src* tied to 00.
//
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   id_src1/2, id_has_src*: ID stage sources and their valids
//   exe_dest, exe_wb_en   : EXE destination; exe_mem_r_en marks a load
//   mem_dest, mem_wb_en   : MEM destination
//   wb_dest, wb_wb_en     : WB destination (forwarding only)
//   exe_src1/2            : EXE operand addresses (forwarding only)
//   branch_taken          : EXE branch taken
//   mem_req, sram_ready   : SRAM request/complete handshake
//   hazard                : stall ID, hold PC and IF/ID
//   flush                 : clear IF/ID and ID/EXE
//   pipe_freeze           : hold all pipeline registers and PC
//   sel_src1/2            : EXE operand forward selects
//   mem_err               : sticky SRAM timeout
//   stall_cnt             : saturating count of hazard cycles
//   fsm_state             : current memory-wait FSM state (debug)
//
// SRAM handshake: an access is in flight while mem_req is high; it completes
// in the cycle sram_ready is high. mem_req & ~sram_ready means the pipeline
// must freeze this cycle. sram_ready with the request rise is a single-cycle
// access and never enters MEM_WAIT.
// ---------------------------------------------------------------------------
module hazard_controller
  import arm_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_has_src1,
  input  logic              id_has_src2,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  input  logic [REG_AW-1:0] exe_src1,
  input  logic [REG_AW-1:0] exe_src2,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              sram_ready,
  output logic              hazard,
  output logic              flush,
  output logic              pipe_freeze,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic              mem_err,
  output logic [15:0]       stall_cnt,
  output logic [1:0]        fsm_state
);

  // Last wait count before the timeout; MEM_TIMEOUT is bounded to 2..255.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  fsm_state_t state;
  logic [7:0] wait_cnt;

  logic raw_exe;
  logic raw;
  logic sram_stall;

  function automatic logic raw_hit(input logic              has_src,
                                   input logic [REG_AW-1:0] src,
                                   input logic              dest_en,
                                   input logic [REG_AW-1:0] dest);
    return has_src && dest_en && (src == dest);
  endfunction

  assign raw_exe = raw_hit(id_has_src1, id_src1, exe_wb_en, exe_dest) ||
                   raw_hit(id_has_src2, id_src2, exe_wb_en, exe_dest);

`ifdef HAZARD_FORWARDING_EN
  // Everything except a load result can be forwarded, so only load-use stalls.
  assign raw = raw_exe && exe_mem_r_en;

  forwarding_unit #(
    .REG_AW (REG_AW)
  ) u_forwarding_unit (
    .exe_src1  (exe_src1),
    .exe_src2  (exe_src2),
    .mem_dest  (mem_dest),
    .mem_wb_en (mem_wb_en),
    .wb_dest   (wb_dest),
    .wb_wb_en  (wb_wb_en),
    .sel_src1  (sel_src1),
    .sel_src2  (sel_src2)
  );
`else
  logic raw_mem;
  logic unused_fwd_inputs;

  assign raw_mem = raw_hit(id_has_src1, id_src1, mem_wb_en, mem_dest) ||
                   raw_hit(id_has_src2, id_src2, mem_wb_en, mem_dest);
  assign raw     = raw_exe || raw_mem;

  assign sel_src1 = FWD_REG;
  assign sel_src2 = FWD_REG;

  // Forwarding-only inputs have no effect in this build.
  assign unused_fwd_inputs = ^{exe_src1, exe_src2, wb_dest, wb_wb_en, exe_mem_r_en};
`endif

  // Priority: freeze masks flush and hazard; flush masks hazard. A branch
  // seen during a freeze simply waits in EXE for the first unfrozen cycle.
  assign sram_stall  = mem_req && !sram_ready;
  assign pipe_freeze = sram_stall || (state == ERROR);
  assign flush       = !pipe_freeze && branch_taken;
  assign hazard      = !pipe_freeze && !branch_taken && raw;

  assign mem_err   = (state == ERROR);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (hazard && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      case (state)
        RUN: begin
          if (sram_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (sram_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERROR: begin
          // Absorbing: only rst leaves ERROR.
          state <= ERROR;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Directed and randomized checking of hazard_controller against a
// behavioural model of the pipeline control rules. Built with the same
// HAZARD_FORWARDING_EN setting as the DUT.
// ---------------------------------------------------------------------------
module tb_hazard_controller;
  import arm_pkg::*;

  localparam int AW     = 4;
  localparam int TB_TO  = 4;
  localparam int SAT_N  = 65540;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] id_src1, id_src2, exe_dest, mem_dest, wb_dest, exe_src1, exe_src2;
  logic          id_has_src1, id_has_src2, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
  logic          branch_taken, mem_req, sram_ready;
  logic          hazard, flush, pipe_freeze, mem_err;
  logic [1:0]    sel_src1, sel_src2, fsm_state;
  logic [15:0]   stall_cnt;

  hazard_controller #(
    .REG_AW      (AW),
    .MEM_TIMEOUT (TB_TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_has_src1  (id_has_src1),
    .id_has_src2  (id_has_src2),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .wb_dest      (wb_dest),
    .wb_wb_en     (wb_wb_en),
    .exe_src1     (exe_src1),
    .exe_src2     (exe_src2),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .sram_ready   (sram_ready),
    .hazard       (hazard),
    .flush        (flush),
    .pipe_freeze  (pipe_freeze),
    .sel_src1     (sel_src1),
    .sel_src2     (sel_src2),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_waited: cycles the current SRAM access has been pending (0 = none).
  int m_waited = 0;
  bit m_err    = 1'b0;
  int m_stall  = 0;

  function automatic bit model_raw();
    bit hit_exe, hit_mem;
    hit_exe = (id_has_src1 && exe_wb_en && id_src1 == exe_dest) ||
              (id_has_src2 && exe_wb_en && id_src2 == exe_dest);
    hit_mem = (id_has_src1 && mem_wb_en && id_src1 == mem_dest) ||
              (id_has_src2 && mem_wb_en && id_src2 == mem_dest);
`ifdef HAZARD_FORWARDING_EN
    return hit_exe && exe_mem_r_en;
`else
    return hit_exe || hit_mem;
`endif
  endfunction

  function automatic logic [1:0] model_sel(input logic [AW-1:0] src);
`ifdef HAZARD_FORWARDING_EN
    if (mem_wb_en && mem_dest == src) return 2'd1;
    if (wb_wb_en && wb_dest == src)   return 2'd2;
    return 2'd0;
`else
    return 2'd0;
`endif
  endfunction

  function automatic bit model_freeze();
    return (mem_req && !sram_ready) || m_err;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_err)             return ERROR;
    else if (m_waited > 0) return MEM_WAIT;
    else                   return RUN;
  endfunction

  // Advance the model by one rising edge, given this cycle's hazard decision.
  task automatic model_clock(input bit hz);
    if (hz && m_stall < 65535) m_stall = m_stall + 1;
    if (!m_err) begin
      if (m_waited == 0) begin
        if (mem_req && !sram_ready) m_waited = 1;
      end else if (sram_ready) begin
        m_waited = 0;
      end else if (m_waited + 1 >= TB_TO) begin
        m_err = 1'b1;
      end else begin
        m_waited = m_waited + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_src1 = '0; id_src2 = '0; id_has_src1 = 0; id_has_src2 = 0;
    exe_dest = '0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = '0; mem_wb_en = 0; wb_dest = '0; wb_wb_en = 0;
    exe_src1 = '0; exe_src2 = '0;
    branch_taken = 0; mem_req = 0; sram_ready = 0;
  endtask

  task automatic drive_random();
    id_src1      = AW'($urandom_range(0, 3));
    id_src2      = AW'($urandom_range(0, 3));
    id_has_src1  = 1'($urandom_range(0, 1));
    id_has_src2  = 1'($urandom_range(0, 1));
    exe_dest     = AW'($urandom_range(0, 3));
    exe_wb_en    = 1'($urandom_range(0, 1));
    exe_mem_r_en = 1'($urandom_range(0, 1));
    mem_dest     = AW'($urandom_range(0, 3));
    mem_wb_en    = 1'($urandom_range(0, 1));
    wb_dest      = AW'($urandom_range(0, 3));
    wb_wb_en     = 1'($urandom_range(0, 1));
    exe_src1     = AW'($urandom_range(0, 3));
    exe_src2     = AW'($urandom_range(0, 3));
    branch_taken = ($urandom_range(0, 5) == 0);
    mem_req      = ($urandom_range(0, 3) == 0);
    sram_ready   = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a falling edge with inputs already driven: checks the
  // combinational outputs, crosses one rising edge, checks registered state.
  task automatic step(input string tag);
    bit         e_fz, e_fl, e_hz;
    logic [1:0] e_s1, e_s2;
    #1;
    e_fz = model_freeze();
    e_fl = !e_fz && branch_taken;
    e_hz = !e_fz && !branch_taken && model_raw();
    e_s1 = model_sel(exe_src1);
    e_s2 = model_sel(exe_src2);
    chk({tag, ".hazard"},      32'(hazard),      32'(e_hz));
    chk({tag, ".flush"},       32'(flush),       32'(e_fl));
    chk({tag, ".pipe_freeze"}, 32'(pipe_freeze), 32'(e_fz));
    chk({tag, ".sel_src1"},    32'(sel_src1),    32'(e_s1));
    chk({tag, ".sel_src2"},    32'(sel_src2),    32'(e_s2));
    @(posedge clk);
    model_clock(e_hz);
    #1;
    chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_stall));
    chk({tag, ".mem_err"},     32'(mem_err),     32'(m_err));
    chk({tag, ".fsm_state"},   32'(fsm_state),   32'(model_state()));
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; effects checked before any edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    m_waited = 0;
    m_err    = 1'b0;
    m_stall  = 0;
    chk({tag, ".rst_stall_cnt"},   32'(stall_cnt),   32'd0);
    chk({tag, ".rst_mem_err"},     32'(mem_err),     32'd0);
    chk({tag, ".rst_pipe_freeze"}, 32'(pipe_freeze), 32'(model_freeze()));
    chk({tag, ".rst_fsm_state"},   32'(fsm_state),   32'(RUN));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fz_cycles;

    rst = 1'b1;
    drive_idle();
    #2;
    chk("reset.stall_cnt",   32'(stall_cnt),   32'd0);
    chk("reset.mem_err",     32'(mem_err),     32'd0);
    chk("reset.hazard",      32'(hazard),      32'd0);
    chk("reset.flush",       32'(flush),       32'd0);
    chk("reset.pipe_freeze", 32'(pipe_freeze), 32'd0);
    chk("reset.sel_src1",    32'(sel_src1),    32'd0);
    chk("reset.sel_src2",    32'(sel_src2),    32'd0);
    chk("reset.fsm_state",   32'(fsm_state),   32'(RUN));
    @(negedge clk);
    rst = 1'b0;
    step("idle");

    // EXE RAW on Rn.
    id_src1 = 4'd3; id_has_src1 = 1; exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 0;
    #1;
`ifdef HAZARD_FORWARDING_EN
    chk("tp_exe_raw_alu.hazard", 32'(hazard), 32'd0);
`else
    chk("tp_exe_raw.hazard", 32'(hazard), 32'd1);
`endif
    step("exe_raw");
    exe_mem_r_en = 1;
    #1;
    chk("tp_load_use.hazard", 32'(hazard), 32'd1);
    step("load_use");

    // MEM RAW via the second source.
    drive_idle();
    id_src2 = 4'd7; id_has_src2 = 1; mem_dest = 4'd7; mem_wb_en = 1;
    step("mem_raw");

    // Forward selects: MEM and WB both match operand 2, WB alone matches operand 1.
    drive_idle();
    mem_dest = 4'd5; mem_wb_en = 1; wb_dest = 4'd5; wb_wb_en = 1; exe_src2 = 4'd5;
    exe_src1 = 4'd9;
    step("fwd_double");
    wb_dest = 4'd9;
    step("fwd_wb");

    // Branch with an active RAW hazard: flush wins, no stall counted.
    drive_idle();
    id_src1 = 4'd2; id_has_src1 = 1; exe_dest = 4'd2; exe_wb_en = 1; exe_mem_r_en = 1;
    branch_taken = 1;
    #1;
    chk("tp_branch_hazard.flush",  32'(flush),  32'd1);
    chk("tp_branch_hazard.hazard", 32'(hazard), 32'd0);
    step("branch_hazard");
    branch_taken = 0;
    step("held_hazard_1");
    step("held_hazard_2");

    // SRAM wait of three cycles, with a branch arriving while frozen.
    drive_idle();
    fz_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      mem_req      = (i < 4);
      sram_ready   = (i == 3);
      branch_taken = (i == 2);
      #1;
      if (pipe_freeze) fz_cycles = fz_cycles + 1;
      step("sram_wait");
    end
    chk("tp_sram_wait.freeze_cycles", 32'(fz_cycles), 32'd3);
    chk("tp_sram_wait.state_run",     32'(fsm_state), 32'(RUN));

    // Single-cycle access: ready with the request rise.
    mem_req = 1; sram_ready = 1;
    step("sram_single");
    drive_idle();

    // Timeout: ready never arrives.
    mem_req = 1; sram_ready = 0;
    for (int i = 0; i < TB_TO; i++) step("timeout");
    chk("tp_timeout.mem_err", 32'(mem_err), 32'd1);
    drive_idle();
    id_src1 = 4'd1; id_has_src1 = 1; exe_dest = 4'd1; exe_wb_en = 1; exe_mem_r_en = 1;
    branch_taken = 1;
    step("error_sticky");
    branch_taken = 0;
    step("error_sticky");
    drive_idle();
    do_reset("error_reset");
    step("after_reset");

    // Randomized traffic with periodic asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if (i % 50 == 49) do_reset("rand");
      step("rand");
    end

    // Saturation: hold a RAW hazard for more than 65535 cycles.
    drive_idle();
    do_reset("sat");
    id_src1 = 4'd4; id_has_src1 = 1; exe_dest = 4'd4; exe_wb_en = 1; exe_mem_r_en = 1;
    for (int i = 0; i < SAT_N; i++) begin
      @(posedge clk);
      if (m_stall < 65535) m_stall = m_stall + 1;
    end
    @(negedge clk);
    chk("sat.hazard",          32'(hazard),    32'd1);
    chk("sat.stall_cnt_model", 32'(stall_cnt), 32'(m_stall));
    chk("tp_sat.stall_cnt",    32'(stall_cnt), 32'h0000FFFF);
    step("sat_hold");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
